// File: rtl/cpu_controller_mc.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
// Drives the IR/PC/register-file strobes and a handshaked memory port that has a wait-state timeout.
module cpu_controller_mc #(
  parameter int OPW      = 4,
  parameter int NREG     = 4,
  parameter int WAIT_MAX = 8,
  parameter int CW       = 16,
  localparam int RW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [OPW-1:0]  opcode,
  input  logic [RW-1:0]   rd,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            load_ir,
  output logic            load_pc,
  output logic            inc_pc,
  output logic [NREG-1:0] load_reg,
  output logic            mem_to_reg,
  output logic            mode,
  output logic [OPW-2:0]  alu_op,
  output logic            halted,
  output logic            err,
  output logic [CW-1:0]   instr_count
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic [3:0]      cls;
  logic [NREG-1:0] dec_reg;
  logic            is_store;
  logic            wait_expired;
  logic            halt_entry;

  assign cls          = opcode[OPW-1:OPW-4];
  assign is_store     = (cls == 4'b0101);
  assign wait_expired = !mem_ready && (wait_cnt == WW'(WAIT_MAX - 1));
  assign dec_reg      = (int'(rd) < NREG) ? (NREG'(1) << rd) : '0;
  assign halted       = (state == S_HALT);
  assign err          = (state == S_ERROR);
  assign halt_entry   = en && (state == S_EXEC) && (cls == 4'b0011);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (en) begin
        if (state_nxt != state)
          wait_cnt <= '0;
        else if (mem_req && !mem_ready)
          wait_cnt <= wait_cnt + WW'(1);
      end
      if ((inc_pc || load_pc || halt_entry) && (instr_count != {CW{1'b1}}))
        instr_count <= instr_count + CW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_reg   = '0;
    mem_to_reg = 1'b0;
    mode       = 1'b0;
    alu_op     = '0;

    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          load_ir   = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_expired) begin
          state_nxt = S_ERROR;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        mode      = opcode[OPW-1];
        alu_op    = opcode[OPW-2:0];
        state_nxt = S_FETCH;
        if (cls[3]) begin
          load_reg = dec_reg;
          inc_pc   = 1'b1;
        end else begin
          case (cls[2:0])
            3'b000, 3'b001: begin
              load_reg = dec_reg;
              inc_pc   = 1'b1;
            end
            3'b010: begin
              load_pc = zero;
              inc_pc  = !zero;
            end
            3'b011:         state_nxt = S_HALT;
            3'b100, 3'b101: state_nxt = S_MEM;
            3'b110:         load_pc   = 1'b1;
            3'b111:         inc_pc    = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          inc_pc    = 1'b1;
          state_nxt = S_FETCH;
          if (!is_store) begin
            load_reg   = dec_reg;
            mem_to_reg = 1'b1;
          end
        end else if (wait_expired) begin
          state_nxt = S_ERROR;
        end
      end
      default: state_nxt = state;
    endcase

    // A stall freezes the sequence and silences the memory port and every strobe.
    if (!en) begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      load_ir    = 1'b0;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      load_reg   = '0;
      mem_to_reg = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller_mc.sv
// Directed bench for cpu_controller_mc: expected output vectors are queued as each step is driven
// and popped/compared against the DUT in the middle of the low clock phase.
module tb_cpu_controller_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  opcode;
  logic [1:0]  rd;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, load_ir, load_pc, inc_pc;
  logic [3:0]  load_reg;
  logic        mem_to_reg, mode;
  logic [2:0]  alu_op;
  logic        halted, err;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_sig_q[$];
  logic [15:0] exp_cnt_q[$];
  string       tag_q[$];

  localparam logic [15:0] Z = 16'h0000;

  cpu_controller_mc #(.OPW(4), .NREG(4), .WAIT_MAX(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .rd(rd), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .load_ir(load_ir), .load_pc(load_pc), .inc_pc(inc_pc), .load_reg(load_reg),
    .mem_to_reg(mem_to_reg), .mode(mode), .alu_op(alu_op), .halted(halted),
    .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, load_ir, load_pc, inc_pc, load_reg,
                mem_to_reg, mode, alu_op, halted, err};

  function automatic logic [15:0] sv(input logic req, input logic we, input logic asel,
                                     input logic ir, input logic lpc, input logic ipc,
                                     input logic [3:0] lreg, input logic m2r, input logic md,
                                     input logic [2:0] aop, input logic h, input logic e);
    return {req, we, asel, ir, lpc, ipc, lreg, m2r, md, aop, h, e};
  endfunction

  task automatic step(input string tag, input logic e_i, input logic [3:0] op_i,
                      input logic [1:0] rd_i, input logic z_i, input logic rdy_i,
                      input logic [15:0] es, input logic [15:0] ec);
    logic [15:0] s_exp, c_exp;
    string t;
    en        = e_i;
    opcode    = op_i;
    rd        = rd_i;
    zero      = z_i;
    mem_ready = rdy_i;
    exp_sig_q.push_back(es);
    exp_cnt_q.push_back(ec);
    tag_q.push_back(tag);
    #2;
    s_exp = exp_sig_q.pop_front();
    c_exp = exp_cnt_q.pop_front();
    t     = tag_q.pop_front();
    n_checks++;
    assert (obs === s_exp) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h", t, obs, s_exp);
    end
    n_checks++;
    assert (instr_count === c_exp) else begin
      n_fail++;
      $error("FAIL %s instr_count: observed %0d expected %0d", t, instr_count, c_exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opcode = '0; rd = '0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    step("reset", 1, 4'h0, 2'd2, 0, 1, Z, 16'd0);
    rst = 1'b0;

    // arithmetic op, zero-wait fetch
    step("t1_idle",   1, 4'h0, 2'd2, 0, 1, Z, 16'd0);
    step("t1_fetch",  1, 4'h0, 2'd2, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd0);
    step("t1_decode", 1, 4'h0, 2'd2, 0, 1, Z, 16'd0);
    step("t1_exec",   1, 4'h0, 2'd2, 0, 1, sv(0,0,0,0,0,1,4'b0100,0,0,3'b000,0,0), 16'd0);

    // LOAD with three wait states
    step("ld_fetch",  1, 4'h4, 2'd1, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd1);
    step("ld_decode", 1, 4'h4, 2'd1, 0, 1, Z, 16'd1);
    step("ld_exec",   1, 4'h4, 2'd1, 0, 1, sv(0,0,0,0,0,0,4'b0000,0,0,3'b100,0,0), 16'd1);
    for (int i = 0; i < 3; i++)
      step("ld_wait", 1, 4'h4, 2'd1, 0, 0, sv(1,0,1,0,0,0,4'b0000,0,0,3'b000,0,0), 16'd1);
    step("ld_done",   1, 4'h4, 2'd1, 0, 1, sv(1,0,1,0,0,1,4'b0010,1,0,3'b000,0,0), 16'd1);

    // JZ taken, then not taken
    step("jz1_fetch",  1, 4'h2, 2'd0, 1, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd2);
    step("jz1_decode", 1, 4'h2, 2'd0, 1, 1, Z, 16'd2);
    step("jz1_exec",   1, 4'h2, 2'd0, 1, 1, sv(0,0,0,0,1,0,4'b0000,0,0,3'b010,0,0), 16'd2);
    step("jz0_fetch",  1, 4'h2, 2'd0, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd3);
    step("jz0_decode", 1, 4'h2, 2'd0, 0, 1, Z, 16'd3);
    step("jz0_exec",   1, 4'h2, 2'd0, 0, 1, sv(0,0,0,0,0,1,4'b0000,0,0,3'b010,0,0), 16'd3);

    // logic-class op
    step("lg_fetch",  1, 4'hB, 2'd3, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd4);
    step("lg_decode", 1, 4'hB, 2'd3, 0, 1, Z, 16'd4);
    step("lg_exec",   1, 4'hB, 2'd3, 0, 1, sv(0,0,0,0,0,1,4'b1000,0,1,3'b011,0,0), 16'd4);

    // STORE: 2 waits, 5-cycle stall, 5 more waits, ready on the last permitted wait cycle
    step("st_fetch",  1, 4'h5, 2'd0, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd5);
    step("st_decode", 1, 4'h5, 2'd0, 0, 1, Z, 16'd5);
    step("st_exec",   1, 4'h5, 2'd0, 0, 1, sv(0,0,0,0,0,0,4'b0000,0,0,3'b101,0,0), 16'd5);
    for (int i = 0; i < 2; i++)
      step("st_wait", 1, 4'h5, 2'd0, 0, 0, sv(1,1,1,0,0,0,4'b0000,0,0,3'b000,0,0), 16'd5);
    for (int i = 0; i < 5; i++)
      step("st_stall", 0, 4'h5, 2'd0, 0, 0, Z, 16'd5);
    for (int i = 0; i < 5; i++)
      step("st_resume", 1, 4'h5, 2'd0, 0, 0, sv(1,1,1,0,0,0,4'b0000,0,0,3'b000,0,0), 16'd5);
    step("st_done",   1, 4'h5, 2'd0, 0, 1, sv(1,1,1,0,0,1,4'b0000,0,0,3'b000,0,0), 16'd5);

    // JMP
    step("jmp_fetch",  1, 4'h6, 2'd0, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd6);
    step("jmp_decode", 1, 4'h6, 2'd0, 0, 1, Z, 16'd6);
    step("jmp_exec",   1, 4'h6, 2'd0, 0, 1, sv(0,0,0,0,1,0,4'b0000,0,0,3'b110,0,0), 16'd6);

    // fetch timeout: eight waiting cycles, then ERROR
    for (int i = 0; i < 8; i++)
      step("to_wait", 1, 4'h0, 2'd0, 0, 0, sv(1,0,0,0,0,0,4'b0000,0,0,3'b000,0,0), 16'd7);
    for (int i = 0; i < 3; i++)
      step("to_error", 1, 4'h0, 2'd0, 0, 1, sv(0,0,0,0,0,0,4'b0000,0,0,3'b000,0,1), 16'd7);
    rst = 1'b1;
    step("err_rst", 1, 4'h0, 2'd0, 0, 1, Z, 16'd0);
    rst = 1'b0;

    // HALT
    step("h_idle",   1, 4'h3, 2'd0, 0, 1, Z, 16'd0);
    step("h_fetch",  1, 4'h3, 2'd0, 0, 1, sv(1,0,0,1,0,0,4'b0000,0,0,3'b000,0,0), 16'd0);
    step("h_decode", 1, 4'h3, 2'd0, 0, 1, Z, 16'd0);
    step("h_exec",   1, 4'h3, 2'd0, 0, 1, sv(0,0,0,0,0,0,4'b0000,0,0,3'b011,0,0), 16'd0);
    for (int i = 0; i < 20; i++)
      step("h_halted", 1, 4'h3, 2'd0, 0, 1, sv(0,0,0,0,0,0,4'b0000,0,0,3'b000,1,0), 16'd1);
    rst = 1'b1;
    step("h_rst", 1, 4'h3, 2'd0, 0, 1, Z, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
